// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the fetch-path pipeline controller
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        HALTED   = 2'd2
    } ctrl_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0040_0004;

    // Wide enough for the longest MDU occupancy minus one (DIV_CYCLES up to 64).
    localparam int MDU_CNT_W = 6;

    function automatic logic [MDU_CNT_W-1:0] mdu_load_value(input int cycles);
        return MDU_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator between EX load and ID sources
module hazard_detect (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    // $zero never carries a real dependency, so a load to r0 never stalls.
    assign rs_match = id_uses_rs && (id_rs == ex_rd);
    assign rt_match = id_uses_rt && (id_rt == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - fetch-path sequencer: PC control, IF/ID and ID/EX stall/flush/bubble
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int          MUL_CYCLES = 4,
    parameter int          DIV_CYCLES = 32,
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        id_mdu_start,
    input  logic        id_mdu_is_div,
    input  logic        id_branch_taken,
    input  logic [31:0] id_branch_target,
    input  logic [31:0] pc_plus4,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        halt_req,
    output logic        pc_enable,
    output logic        pc_stall,
    output logic [31:0] next_pc,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        mdu_busy
);

    ctrl_state_t          state, state_d;
    logic [MDU_CNT_W-1:0] mdu_cnt, mdu_cnt_d;
    logic                 load_use;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .load_use    (load_use)
    );

    always_comb begin
        pc_enable    = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        next_pc      = pc_plus4;
        state_d      = state;
        mdu_cnt_d    = mdu_cnt;

        if (!reset) begin
            next_pc   = RESET_PC;
            state_d   = RUN;
            mdu_cnt_d = '0;
        end else if (state == HALTED) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (exc_req || eret_req) begin
            // Redirects abort any MDU wait; exception wins over ERET.
            next_pc      = exc_req ? EXC_VECTOR : epc;
            pc_enable    = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = RUN;
            mdu_cnt_d    = '0;
        end else if (halt_req) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = HALTED;
            mdu_cnt_d    = '0;
        end else if (state == MDU_WAIT) begin
            pc_enable    = 1'b1;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            if (mdu_cnt == '0) begin
                state_d = RUN;
            end else begin
                mdu_cnt_d = mdu_cnt - MDU_CNT_W'(1);
            end
        end else if (load_use) begin
            pc_enable    = 1'b1;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            // MDU issue and a taken branch may coincide; both take effect.
            pc_enable = 1'b1;
            if (id_mdu_start) begin
                mdu_cnt_d = id_mdu_is_div ? mdu_load_value(DIV_CYCLES)
                                          : mdu_load_value(MUL_CYCLES);
                state_d   = MDU_WAIT;
            end
            if (id_branch_taken) begin
                next_pc     = id_branch_target;
                if_id_flush = 1'b1;
            end
        end
    end

    assign mdu_busy = reset && (state == MDU_WAIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else begin
            state   <= state_d;
            mdu_cnt <= mdu_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed self-checking bench for pipeline_controller
module tb_pipeline_controller;

    logic        clock;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, ex_mem_read;
    logic        id_mdu_start, id_mdu_is_div, id_branch_taken;
    logic [31:0] id_branch_target, pc_plus4, epc;
    logic        exc_req, eret_req, halt_req;
    logic        pc_enable, pc_stall, if_id_stall, if_id_flush, id_ex_bubble, mdu_busy;
    logic [31:0] next_pc;

    int n_assert = 0;
    int n_fail   = 0;
    int busy_cnt;

    // Control vector order: pc_enable, pc_stall, if_id_stall, if_id_flush, id_ex_bubble, mdu_busy
    logic [5:0] ctl;
    assign ctl = {pc_enable, pc_stall, if_id_stall, if_id_flush, id_ex_bubble, mdu_busy};

    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_RUN   = 6'b100000;
    localparam logic [5:0] C_STALL = 6'b111010;
    localparam logic [5:0] C_MDU   = 6'b111011;
    localparam logic [5:0] C_REDIR = 6'b100110;
    localparam logic [5:0] C_BR    = 6'b100100;
    localparam logic [5:0] C_HALT  = 6'b011010;

    pipeline_controller #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32),
        .RESET_PC   (32'h0040_0000),
        .EXC_VECTOR (32'h0040_0004)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .ex_mem_read      (ex_mem_read),
        .ex_rd            (ex_rd),
        .id_mdu_start     (id_mdu_start),
        .id_mdu_is_div    (id_mdu_is_div),
        .id_branch_taken  (id_branch_taken),
        .id_branch_target (id_branch_target),
        .pc_plus4         (pc_plus4),
        .exc_req          (exc_req),
        .eret_req         (eret_req),
        .epc              (epc),
        .halt_req         (halt_req),
        .pc_enable        (pc_enable),
        .pc_stall         (pc_stall),
        .next_pc          (next_pc),
        .if_id_stall      (if_id_stall),
        .if_id_flush      (if_id_flush),
        .id_ex_bubble     (id_ex_bubble),
        .mdu_busy         (mdu_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        id_mdu_start = 1'b0; id_mdu_is_div = 1'b0; id_branch_taken = 1'b0;
        id_branch_target = 32'h0000_ABC0; epc = 32'h0000_1234;
        exc_req = 1'b0; eret_req = 1'b0; halt_req = 1'b0;
    endtask

    task automatic count_busy(input int limit, output int cycles);
        cycles = 0;
        for (int i = 0; i < limit; i++) begin
            if (!mdu_busy) break;
            chk("mdu_wait_ctl", 32'(ctl), 32'(C_MDU));
            cycles++;
            tick();
            settle();
        end
    endtask

    initial begin
        clear_inputs();
        pc_plus4 = 32'h0000_0104;
        reset    = 1'b0;

        // Reset dominates even with requests present.
        exc_req = 1'b1; id_branch_taken = 1'b1;
        #3;
        chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
        chk("reset_pc", next_pc, 32'h0040_0000);
        clear_inputs();
        tick(); tick();
        reset = 1'b1;
        settle();
        chk("run_ctl", 32'(ctl), 32'(C_RUN));
        chk("run_pc", next_pc, 32'h0000_0104);

        // Load-use on rs
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        settle();
        chk("lu_rs_ctl", 32'(ctl), 32'(C_STALL));
        chk("lu_rs_pc", next_pc, 32'h0000_0104);
        tick();
        clear_inputs();
        settle();
        chk("lu_after_ctl", 32'(ctl), 32'(C_RUN));

        // Load to r0 never stalls
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        settle();
        chk("lu_r0_ctl", 32'(ctl), 32'(C_RUN));

        // Load-use on rt, then the same registers with rt unused
        tick();
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
        settle();
        chk("lu_rt_ctl", 32'(ctl), 32'(C_STALL));
        tick();
        id_uses_rt = 1'b0;
        settle();
        chk("lu_rt_unused_ctl", 32'(ctl), 32'(C_RUN));

        // Divide: issue cycle proceeds, then 32 busy cycles
        tick();
        clear_inputs();
        id_mdu_start = 1'b1; id_mdu_is_div = 1'b1;
        settle();
        chk("div_issue_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        clear_inputs();
        settle();
        count_busy(100, busy_cnt);
        chk("div_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("div_done_ctl", 32'(ctl), 32'(C_RUN));

        // Multiply: 4 busy cycles
        tick();
        id_mdu_start = 1'b1; id_mdu_is_div = 1'b0;
        settle();
        tick();
        clear_inputs();
        settle();
        count_busy(100, busy_cnt);
        chk("mul_busy_cycles", 32'(busy_cnt), 32'd4);

        // Exception in the 10th divide-wait cycle aborts the wait
        tick();
        id_mdu_start = 1'b1; id_mdu_is_div = 1'b1;
        settle();
        tick();
        clear_inputs();
        for (int i = 0; i < 9; i++) tick();
        exc_req = 1'b1;
        settle();
        chk("exc_ctl", 32'(ctl[5:1]), 32'(C_REDIR[5:1]));
        chk("exc_pc", next_pc, 32'h0040_0004);
        tick();
        clear_inputs();
        settle();
        chk("exc_after_ctl", 32'(ctl), 32'(C_RUN));

        // ERET
        tick();
        eret_req = 1'b1;
        settle();
        chk("eret_ctl", 32'(ctl), 32'(C_REDIR));
        chk("eret_pc", next_pc, 32'h0000_1234);

        // Branch coincident with load-use: stall first, redirect next cycle
        tick();
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1; id_branch_taken = 1'b1;
        settle();
        chk("br_lu_ctl", 32'(ctl), 32'(C_STALL));
        chk("br_lu_pc", next_pc, 32'h0000_0104);
        tick();
        ex_mem_read = 1'b0;
        settle();
        chk("br_ctl", 32'(ctl), 32'(C_BR));
        chk("br_pc", next_pc, 32'h0000_ABC0);

        // Branch and multiply issue together both take effect
        tick();
        id_mdu_start = 1'b1;
        settle();
        chk("br_mdu_ctl", 32'(ctl), 32'(C_BR));
        chk("br_mdu_pc", next_pc, 32'h0000_ABC0);
        tick();
        clear_inputs();
        settle();
        count_busy(100, busy_cnt);
        chk("br_mdu_busy_cycles", 32'(busy_cnt), 32'd4);

        // Halt is permanent and ignores exceptions
        tick();
        halt_req = 1'b1;
        settle();
        chk("halt_ctl", 32'(ctl), 32'(C_HALT));
        tick();
        clear_inputs();
        exc_req = 1'b1;
        settle();
        chk("halted_exc_ctl", 32'(ctl), 32'(C_HALT));
        tick(); tick();
        settle();
        chk("halted_later_ctl", 32'(ctl), 32'(C_HALT));

        // Asynchronous reset mid-cycle, then RUN after release
        reset = 1'b0;
        #1;
        chk("halt_reset_ctl", 32'(ctl), 32'(C_IDLE));
        chk("halt_reset_pc", next_pc, 32'h0040_0000);
        clear_inputs();
        tick();
        reset = 1'b1;
        settle();
        chk("post_reset_ctl", 32'(ctl), 32'(C_RUN));
        chk("post_reset_pc", next_pc, 32'h0000_0104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central sequencer for the 5-stage MIPS pipeline's fetch path. Produces the program counter's `enable`/`stall_signal`/`next_pc` controls and the IF/ID and ID/EX stall, flush and bubble signals. Resolves load-use hazards, multi-cycle multiply/divide waits, taken branches, exceptions/ERET and halt. Sits between ID-stage decode, the EX-stage MDU and the program counter register.

## Interface
- `MUL_CYCLES`, 4: multiply occupancy in cycles, ≥1.
- `DIV_CYCLES`, 32: divide occupancy in cycles, ≥1.
- `RESET_PC`, 32'h00400000: value driven on `next_pc` during reset.
- `EXC_VECTOR`, 32'h00400004: exception handler entry.
- `clock  in  1`: single clock, rising edge.
- `reset  in  1`: asynchronous, active-low.
- `id_rs`, `id_rt  in  5`: source registers of the ID instruction.
- `id_uses_rs`, `id_uses_rt  in  1`: the ID instruction reads that source.
- `ex_mem_read  in  1`: EX instruction is a load.
- `ex_rd  in  5`: EX destination register.
- `id_mdu_start  in  1`: ID instruction is mult/div and issues this cycle.
- `id_mdu_is_div  in  1`: selects `DIV_CYCLES` when issuing.
- `id_branch_taken  in  1`: branch/jump resolved taken in ID.
- `id_branch_target  in  32`: target address.
- `pc_plus4  in  32`: sequential next address.
- `exc_req`, `eret_req  in  1`: exception / return request from MEM.
- `epc  in  32`: return address for ERET.
- `halt_req  in  1`: halt instruction committed.
- `pc_enable  out  1`: drives PC `enable`.
- `pc_stall  out  1`: drives PC `stall_signal`.
- `next_pc  out  32`: drives PC `next_pc`.
- `if_id_stall`, `if_id_flush  out  1`: IF/ID register hold / clear.
- `id_ex_bubble  out  1`: inserts a NOP into ID/EX.
- `mdu_busy  out  1`: high while in MDU_WAIT.

## Operation
- States: RUN, MDU_WAIT, HALTED. A 6-bit down-counter `mdu_cnt` is present.
- Load-use hazard: `ex_mem_read && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd))`.
- Priority per cycle, highest first. Each rule's outputs are listed; any output not listed is 0.
  1. HALTED: `pc_enable=0`, `pc_stall=1`, `if_id_stall=1`, `id_ex_bubble=1`. All requests are ignored.
  2. `exc_req`: `next_pc=EXC_VECTOR`, `pc_enable=1`, `if_id_flush=1`, `id_ex_bubble=1`. Go to RUN and clear `mdu_cnt`, aborting any MDU wait.
  3. `eret_req`: same as rule 2 with `next_pc=epc`.
  4. `halt_req`: go to HALTED next cycle. Outputs for this cycle are those of rule 1.
  5. MDU_WAIT: `pc_enable=1`, `pc_stall=1`, `if_id_stall=1`, `id_ex_bubble=1`. Decrement `mdu_cnt`; when it is 0, go to RUN.
  6. Load-use hazard in RUN: `pc_enable=1`, `pc_stall=1`, `if_id_stall=1`, `id_ex_bubble=1`. Branch and MDU issue are deferred to the next cycle.
  7. `id_mdu_start` in RUN: proceed normally this cycle. Load `mdu_cnt` with (`DIV_CYCLES` or `MUL_CYCLES`) − 1 and go to MDU_WAIT.
  8. `id_branch_taken` in RUN: `pc_enable=1`, `next_pc=id_branch_target`, `if_id_flush=1`. No delay slot.
  9. Otherwise: `pc_enable=1`, `next_pc=pc_plus4`.
- If rules 7 and 8 apply in the same cycle, both take effect.
- Whenever a rule does not redirect the PC, `next_pc=pc_plus4`.

## Timing
- All outputs are combinational from state, `mdu_cnt` and inputs. State and counter update on the rising edge of `clock`.
- While `reset`=0:
  - state = RUN, `mdu_cnt` = 0.
  - All 1-bit outputs are 0 and `next_pc=RESET_PC`.
  - Normal rules apply from the first edge after release.
- Load-use stall lasts exactly 1 cycle.
- An MDU issue causes exactly N stall cycles after the issue cycle, with N = `DIV_CYCLES` or `MUL_CYCLES`. Fetch resumes in cycle N+1.
- A redirect (branch, exception, ERET) takes effect at the next edge with a 1-instruction flush penalty.
- Asserting reset during MDU_WAIT or HALTED returns to RUN immediately (asynchronous).

## Structure
- Package `pipeline_ctrl_pkg`:
  - state enum {RUN, MDU_WAIT, HALTED};
  - `RESET_PC` and `EXC_VECTOR` defaults;
  - the `mdu_cnt` width constant.
- Sub-module `hazard_detect`: purely combinational load-use comparator, reused by the forwarding unit.

## Test plan
- Reset held low → `next_pc`=0x00400000, all controls 0. After release, with no requests, `pc_enable`=1 and `next_pc`=`pc_plus4`.
- `ex_mem_read`=1, `ex_rd`=8, `id_rs`=8, `id_uses_rs`=1 → one cycle of `pc_stall`/`if_id_stall`/`id_ex_bubble`=1. Repeat with `ex_rd`=0 → no stall.
- `id_mdu_start` with `id_mdu_is_div`=1 → `mdu_busy`=1 for exactly 32 cycles, then RUN. With `MUL_CYCLES`=4, a multiply gives 4 cycles.
- `exc_req` in the 10th MDU_WAIT cycle → `next_pc`=0x00400004, flush and bubble asserted, `mdu_busy`=0 next cycle.
- `id_branch_taken` coincident with a load-use hazard → stall first. Next cycle `next_pc`=`id_branch_target` with `if_id_flush`=1.
- `halt_req` → `pc_enable`=0 permanently. `exc_req` ignored. Asserting reset restores RUN.
